ks_serial_add_ctrl: RTL

Sequencing controller that performs multi-nibble add/subtract on wide operands by time-multiplexing one 4-bit Kogge-Stone adder slice with carry-in. It accepts one operation over a valid/ready handshake, runs the slice once per nibble from LSB to MSB while chaining the carry in a register, and returns the full-width result with carry-out and signed overflow. It sits between the tile I/O and the adder slice, so a wide adder costs one 4-bit slice plus registers.

---
 rtl/ks_pkg.sv | 19 +
 rtl/ks_add4_cin.sv | 37 +++
 rtl/ks_serial_add_ctrl.sv | 95 +++++++++
 3 files changed

// File: rtl/ks_pkg.sv
// Shared constants and state type for the serial Kogge-Stone add/subtract controller.
package ks_pkg;

  localparam int NIB = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/ks_add4_cin.sv
// Combinational 4-bit Kogge-Stone adder slice with carry-in and carry-into-MSB tap.
module ks_add4_cin (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       c3
);

  logic [3:0] p;
  logic [3:0] g;
  logic       g0_c;
  logic       g1_1, g1_2, g1_3;
  logic       p1_2, p1_3;
  logic       g2_2, g2_3;

  assign p = a ^ b;
  assign g = a & b;

  // cin behaves as the generate of a virtual bit -1, folded into bit 0
  assign g0_c = g[0] | (p[0] & cin);

  assign g1_1 = g[1] | (p[1] & g0_c);
  assign g1_2 = g[2] | (p[2] & g[1]);
  assign g1_3 = g[3] | (p[3] & g[2]);
  assign p1_2 = p[2] & p[1];
  assign p1_3 = p[3] & p[2];

  assign g2_2 = g1_2 | (p1_2 & g0_c);
  assign g2_3 = g1_3 | (p1_3 & g1_1);

  assign sum  = p ^ {g2_2, g1_1, g0_c, cin};
  assign c3   = g2_2;
  assign cout = g2_3;

endmodule

// File: rtl/ks_serial_add_ctrl.sv
// Wide add/subtract built by stepping one 4-bit Kogge-Stone slice across the operands, LSB nibble first.
module ks_serial_add_ctrl
  import ks_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 op,
  input  logic [NIB*WORDS-1:0] a,
  input  logic [NIB*WORDS-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NIB*WORDS-1:0] sum,
  output logic                 cout,
  output logic                 ovf
);

  localparam int W     = NIB * WORDS;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  state_e           state_q;
  logic [W-1:0]     a_q, b_q, sum_q;
  logic [W-1:0]     b_d, sum_d;
  logic             carry_q, cout_q, ovf_q;
  logic [IDX_W-1:0] idx_q;

  logic [NIB-1:0]   slice_sum;
  logic             slice_cout, slice_c3;

  ks_add4_cin u_slice (
    .a    (a_q[NIB-1:0]),
    .b    (b_q[NIB-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout),
    .c3   (slice_c3)
  );

  // subtract is a + ~b + 1: invert B on load and seed the carry with op
  assign b_d   = (op == OP_ADD) ? b : ~b;
  assign sum_d = {slice_sum, sum_q[W-1:NIB]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b_d;
            carry_q <= (op == OP_SUB);
            idx_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          a_q     <= a_q >> NIB;
          b_q     <= b_q >> NIB;
          sum_q   <= sum_d;
          carry_q <= slice_cout;
          if (idx_q == LAST) begin
            cout_q  <= slice_cout;
            ovf_q   <= slice_c3 ^ slice_cout;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
